// File: rtl/repetition_tx.sv
`default_nettype none
// ============================================================================
// Module      : repetition_tx
// Description : Serial transmitter for a repetition-coded link. Accepts a
//               DATA_W-bit word over valid/ready and sends every data bit
//               REP consecutive times, LSB first, one code bit per clock.
//               The far end majority-votes each REP-bit group.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : DATA_W - data word width
//               REP    - copies per data bit (odd, >= 3)
// Ports       : clk      - system clock, rising edge
//               rst_n    - asynchronous active-low reset
//               in_val   - producer offers a word
//               in_rdy   - word can be accepted this cycle (combinational)
//               in_data  - word to transmit, sampled on accept
//               tx_out   - current code bit
//               tx_val   - tx_out is valid
//               tx_sof   - first code bit of a frame
//               busy     - frame in progress (same as tx_val)
// Option      : REPETITION_TX_ERR_INJECT_EN adds inj_en / inj_bit / inj_copy,
//               sampled on accept; inverts the one code bit at
//               (inj_bit, inj_copy) when inj_en was set.
// ============================================================================
module repetition_tx #(
    parameter int DATA_W = 8,
    parameter int REP    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_val,
    output logic              in_rdy,
    input  logic [DATA_W-1:0] in_data,
`ifdef REPETITION_TX_ERR_INJECT_EN
    input  logic                                            inj_en,
    input  logic [((DATA_W > 1) ? $clog2(DATA_W) : 1)-1:0] inj_bit,
    input  logic [((REP > 1) ? $clog2(REP) : 1)-1:0]       inj_copy,
`endif
    output logic              tx_out,
    output logic              tx_val,
    output logic              tx_sof,
    output logic              busy
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CW = (REP > 1) ? $clog2(REP) : 1;

    localparam logic [BW-1:0] c_LAST_BIT  = BW'(DATA_W - 1);
    localparam logic [CW-1:0] c_LAST_COPY = CW'(REP - 1);
    localparam logic [BW-1:0] c_BIT_ONE   = BW'(1);
    localparam logic [CW-1:0] c_COPY_ONE  = CW'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t              state_q,    state_d;
    logic [DATA_W-1:0]   shift_q,    shift_d;
    logic [BW-1:0]       bit_cnt_q,  bit_cnt_d;
    logic [CW-1:0]       copy_cnt_q, copy_cnt_d;
    logic                tx_out_q,   tx_out_d;
    logic                tx_val_q,   tx_val_d;
    logic                tx_sof_q,   tx_sof_d;

    logic                w_last;
    logic                w_accept;
    logic                w_code;
    logic                w_flip;

    // Counters and outputs are registered together, so (bit_cnt_q, copy_cnt_q)
    // always name the code bit currently on tx_out. The next-state values
    // therefore name the code bit that will appear after the coming edge.
    always_comb begin
        w_last   = (state_q == ST_SEND) && (bit_cnt_q == c_LAST_BIT) &&
                   (copy_cnt_q == c_LAST_COPY);
        in_rdy   = (state_q == ST_IDLE) || w_last;
        w_accept = in_val && in_rdy;

        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        copy_cnt_d = copy_cnt_q;
        tx_val_d   = 1'b0;
        tx_sof_d   = 1'b0;

        if (w_accept) begin
            // Also covers the last code bit, giving gapless back-to-back frames.
            state_d    = ST_SEND;
            shift_d    = in_data;
            bit_cnt_d  = '0;
            copy_cnt_d = '0;
            tx_val_d   = 1'b1;
            tx_sof_d   = 1'b1;
        end else if (w_last) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_SEND) begin
            tx_val_d = 1'b1;
            if (copy_cnt_q == c_LAST_COPY) begin
                copy_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + c_BIT_ONE;
                shift_d    = shift_q >> 1;
            end else begin
                copy_cnt_d = copy_cnt_q + c_COPY_ONE;
            end
        end

        w_code   = tx_val_d & shift_d[0];
        tx_out_d = w_code ^ w_flip;
    end

`ifdef REPETITION_TX_ERR_INJECT_EN
    logic          inj_en_q,   inj_en_d;
    logic [BW-1:0] inj_bit_q,  inj_bit_d;
    logic [CW-1:0] inj_copy_q, inj_copy_d;

    // Injection settings travel with the word; out-of-range indices can never
    // match because the counters never pass their terminal values.
    always_comb begin
        inj_en_d   = inj_en_q;
        inj_bit_d  = inj_bit_q;
        inj_copy_d = inj_copy_q;
        if (w_accept) begin
            inj_en_d   = inj_en;
            inj_bit_d  = inj_bit;
            inj_copy_d = inj_copy;
        end
        w_flip = tx_val_d && inj_en_d && (inj_bit_d == bit_cnt_d) &&
                 (inj_copy_d == copy_cnt_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_en_q   <= 1'b0;
            inj_bit_q  <= '0;
            inj_copy_q <= '0;
        end else begin
            inj_en_q   <= inj_en_d;
            inj_bit_q  <= inj_bit_d;
            inj_copy_q <= inj_copy_d;
        end
    end
`else
    assign w_flip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            copy_cnt_q <= '0;
            tx_out_q   <= 1'b0;
            tx_val_q   <= 1'b0;
            tx_sof_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            copy_cnt_q <= copy_cnt_d;
            tx_out_q   <= tx_out_d;
            tx_val_q   <= tx_val_d;
            tx_sof_q   <= tx_sof_d;
        end
    end

    assign tx_out = tx_out_q;
    assign tx_val = tx_val_q;
    assign tx_sof = tx_sof_q;
    assign busy   = tx_val_q;

endmodule
`default_nettype wire
